// File: rtl/spectrum_bar_render_if.sv
// Bin stream carrying FFT magnitudes into spectrum_bar_render.
// The master drives valid/mag/last; the slave returns ready.
interface spectrum_bar_render_if;
  logic        bin_valid;
  logic        bin_ready;
  logic [15:0] bin_mag;
  logic        bin_last;

  modport master (output bin_valid, output bin_mag, output bin_last, input bin_ready);
  modport slave  (input bin_valid, input bin_mag, input bin_last, output bin_ready);
endinterface

// File: rtl/spectrum_bar_render.sv
// Converts 64 magnitude bins to bar heights and renders them into the back bank of the LED frame RAM.
// Optional build macro PEAK_HOLD_EN adds per-column decaying white peak markers.
module spectrum_bar_render #(
  parameter int SHIFT        = 10,
  parameter int DECAY_FRAMES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  spectrum_bar_render_if.slave        bin_if,
  input  logic                        mtx_done,
  output logic                        wr_en,
  output logic [9:0]                  wr_addr,
  output logic [23:0]                 wr_data,
  output logic                        disp_bank
);

  typedef enum logic [1:0] {COLLECT, RENDER, WAIT_SWAP} state_t;

  generate
    if (DECAY_FRAMES < 1 || SHIFT < 0) begin : g_param_check
      $error("spectrum_bar_render: DECAY_FRAMES must be >= 1 and SHIFT >= 0");
    end
  endgenerate

  state_t      state_reg;
  logic [5:0]  idx_reg;
  logic [9:0]  a_reg;
  logic        bin_ready_reg;
  logic        wr_en_reg;
  logic [9:0]  wr_addr_reg;
  logic [23:0] wr_data_reg;
  logic        disp_bank_reg;

  logic        accept;
  logic        end_collect;
  logic [15:0] mag_sh;
  logic [4:0]  h_new;
  logic        decay_tick;
  logic [4:0]  h_arr [64];
  logic [4:0]  p_arr [64];
  logic [4:0]  h_cur;
  logic [4:0]  p_cur;
  logic [23:0] word_next;

  assign accept      = bin_if.bin_valid && bin_ready_reg && (state_reg == COLLECT);
  assign end_collect = accept && ((idx_reg == 6'd63) || bin_if.bin_last);
  assign mag_sh      = bin_if.bin_mag >> SHIFT;
  assign h_new       = (mag_sh > 16'd16) ? 5'd16 : mag_sh[4:0];

  // Each column latches its own bin; an early bin_last zero-fills every column after idx.
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_col
      logic       hit;
      logic       fill;
      logic [4:0] hv;
      logic [4:0] h_reg;

      assign hit  = accept && (idx_reg == 6'(gi));
      assign fill = accept && bin_if.bin_last && (6'(gi) > idx_reg);
      assign hv   = hit ? h_new : 5'd0;

      always_ff @(posedge clk) begin
        if (rst)              h_reg <= 5'd0;
        else if (hit || fill) h_reg <= hv;
      end
      assign h_arr[gi] = h_reg;

`ifdef PEAK_HOLD_EN
      logic [4:0] p_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          p_reg <= 5'd0;
        end else if (hit || fill) begin
          if (hv >= p_reg)                      p_reg <= hv;
          else if (decay_tick && p_reg != 5'd0) p_reg <= p_reg - 5'd1;
        end
      end
      assign p_arr[gi] = p_reg;
`else
      assign p_arr[gi] = 5'd0;
`endif
    end
  endgenerate

`ifdef PEAK_HOLD_EN
  localparam int FCW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  logic [FCW-1:0] frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (state_reg == WAIT_SWAP && mtx_done) begin
      if (frame_cnt_reg == FCW'(DECAY_FRAMES - 1)) frame_cnt_reg <= '0;
      else                                         frame_cnt_reg <= frame_cnt_reg + 1'b1;
    end
  end
  assign decay_tick = (frame_cnt_reg == FCW'(DECAY_FRAMES - 1));
`else
  assign decay_tick = 1'b0;
`endif

  // Row 0 is the top; a bar of height h lights rows 16-h..15.
  function automatic logic [11:0] pix(input logic [4:0] r, input logic [4:0] h, input logic [4:0] p);
    logic [11:0] c;
    c = 12'h000;
    if (r >= 5'd16 - h) begin
      if (r < 5'd4)      c = 12'h00F;
      else if (r < 5'd8) c = 12'h0FF;
      else               c = 12'h0F0;
    end
    if (p != 5'd0 && r == 5'd16 - p) c = 12'hFFF;
    return c;
  endfunction

  always_comb begin
    h_cur     = h_arr[a_reg[5:0]];
    p_cur     = p_arr[a_reg[5:0]];
    word_next = {pix({2'b01, a_reg[8:6]}, h_cur, p_cur), pix({2'b00, a_reg[8:6]}, h_cur, p_cur)};
  end

  // a_reg runs one step past 511 so the final write drains before WAIT_SWAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= COLLECT;
      idx_reg       <= 6'd0;
      a_reg         <= 10'd0;
      bin_ready_reg <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= 10'd0;
      wr_data_reg   <= 24'd0;
      disp_bank_reg <= 1'b0;
    end else begin
      case (state_reg)
        COLLECT: begin
          wr_en_reg <= 1'b0;
          if (end_collect) begin
            state_reg     <= RENDER;
            bin_ready_reg <= 1'b0;
            idx_reg       <= 6'd0;
            a_reg         <= 10'd0;
          end else begin
            bin_ready_reg <= 1'b1;
            if (accept) idx_reg <= idx_reg + 6'd1;
          end
        end
        RENDER: begin
          if (!a_reg[9]) begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= {~disp_bank_reg, a_reg[8:0]};
            wr_data_reg <= word_next;
            a_reg       <= a_reg + 10'd1;
          end else begin
            wr_en_reg <= 1'b0;
            state_reg <= WAIT_SWAP;
          end
        end
        WAIT_SWAP: begin
          wr_en_reg <= 1'b0;
          if (mtx_done) begin
            disp_bank_reg <= ~disp_bank_reg;
            bin_ready_reg <= 1'b1;
            idx_reg       <= 6'd0;
            state_reg     <= COLLECT;
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

  assign bin_if.bin_ready = bin_ready_reg;
  assign wr_en            = wr_en_reg;
  assign wr_addr          = wr_addr_reg;
  assign wr_data          = wr_data_reg;
  assign disp_bank        = disp_bank_reg;

endmodule

// File: doc/spectrum_bar_render.md
# spectrum_bar_render

Renders a 64-bin audio spectrum as a bar graph into a double-buffered frame RAM that is scanned by the 64x16 LED matrix driver. It accepts FFT magnitude bins over a valid/ready handshake and converts each bin to a 0..16-pixel bar height. It then writes all 512 pixel-pair words into the back bank and swaps banks on the driver's frame `done` pulse, so the panel never shows a half-drawn frame.

## Interface
Parameters:
- `SHIFT`, 10: right shift applied to a bin magnitude before saturation to a height of 16.
- `DECAY_FRAMES`, 4: number of frames per one-pixel peak decay step; used only with peak hold.

Ports:
- `clk`, input, 1: system clock. One clock domain.
- `rst`, input, 1: reset. Synchronous, active-high.
- `bin_valid`, input, 1: a magnitude bin is offered.
- `bin_ready`, output, 1: the block accepts a bin this cycle.
- `bin_mag`, input, 16: unsigned bin magnitude.
- `bin_last`, input, 1: marks the final bin of a spectrum.
- `mtx_done`, input, 1: single-cycle end-of-frame pulse from the LED matrix driver.
- `wr_en`, output, 1: frame RAM write strobe.
- `wr_addr`, output, 10: frame RAM write address, `{bank, rowaddr[2:0], col[5:0]}`.
- `wr_data`, output, 24: pixel pair. Bit fields: `[3:0]` R1, `[7:4]` G1, `[11:8]` B1, `[15:12]` R2, `[19:16]` G2, `[23:20]` B2.
- `disp_bank`, output, 1: the bank the driver reads; forms the MSB of the driver's RAM address.

## Operation
- State machine: COLLECT → RENDER → WAIT_SWAP → COLLECT.
- COLLECT:
  - `bin_ready`=1.
  - A bin is accepted when `bin_valid && bin_ready`. It is stored at index `idx` (0..63) as `h = min(16, bin_mag >> SHIFT)`.
  - After the 64th accepted bin, go to RENDER.
  - If `bin_last` is accepted with `idx`<63, all remaining columns get h=0 and the block goes to RENDER. `bin_last` on bin 63 has no extra effect.
- RENDER:
  - `bin_ready`=0.
  - Counter `a` runs 0..511. `col = a[5:0]`, `rp = a[8:6]`.
  - Upper pixel uses row `rp`; lower pixel uses row `rp+8`. Row 0 is the top of the panel.
  - A pixel at row r in column c is lit iff `r >= 16 - h[c]`.
  - Colour of a lit pixel depends on r:
    - rows 0-3: red (R=F).
    - rows 4-7: yellow (R=F, G=F).
    - rows 8-15: green (G=F).
  - Unlit pixels are all zero. Blue channels are 0 unless peak hold is compiled in.
  - Writes go to bank `~disp_bank`. After `a`=511 is written, go to WAIT_SWAP.
- WAIT_SWAP: on the first `mtx_done` seen in this state, toggle `disp_bank` and return to COLLECT with `idx`=0.
- `mtx_done` in COLLECT or RENDER is ignored.
- Reset mid-render aborts the render. Reset values:
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `bin_ready`=0, `disp_bank`=0.
  - state COLLECT, `idx`=0, all heights and peaks 0, frame counter 0.

## Timing
- All outputs are registered.
- `bin_ready` rises in the first cycle after `rst` deasserts. It falls in the cycle after the accepting handshake that ends collection.
- Render pipeline:
  - `a`=0 is produced in the first RENDER cycle.
  - `wr_en`/`wr_addr`/`wr_data` for address `a` appear one cycle later.
  - 512 consecutive `wr_en` cycles with no gaps.
- WAIT_SWAP is entered the cycle after the last write.
- `mtx_done` sampled in WAIT_SWAP toggles `disp_bank` on the next edge; `bin_ready`=1 on that same edge.
- `mtx_done` coinciding with the last write is ignored; the swap waits for the following `done`.
- Best-case spectrum-to-display latency: 64 accept cycles + 513 render cycles + the wait for `mtx_done`.

## Configuration
- `PEAK_HOLD_EN` defined: a per-column peak register `p[c]` (0..16) is maintained.
  - On each accepted bin: if `h >= p`, then `p = h`. Otherwise, if the decay tick is active and `p > 0`, then `p = p - 1`.
  - The decay tick is active during the whole collection in which the frame counter equals `DECAY_FRAMES-1`. The frame counter increments per completed swap and wraps to 0.
  - Columns zero-filled by an early `bin_last` update their peaks the same way, using h=0.
  - When `p > 0`, the pixel at row `16-p` is drawn white (R=G=B=F), overriding the bar colour.
- `PEAK_HOLD_EN` undefined: no peak registers or frame counter exist, and output is pure bars.

## Test plan
- Reset, then 64 bins with `bin_mag`=16'hFFFF → 512 writes to bank 1; row-0 words have R=F, G=0; row-8 words have G=F; after `mtx_done`, `disp_bank`=1.
- Bin 5 = 16'h0C00 (SHIFT 10 → h=3), others 0 → only column 5 rows 13-15 lit green (lower pixel of rp 5,6,7); all other words 0.
- `bin_last` on the 10th bin → render starts; columns 10-63 are all zero; exactly 512 writes.
- `mtx_done` pulses during RENDER and on the last write cycle → `disp_bank` unchanged; the next `done` in WAIT_SWAP toggles it.
- `rst` asserted at `a`=200 → `wr_en`=0 next cycle, `disp_bank`=0, `bin_ready`=1 one cycle after release.
- `PEAK_HOLD_EN`, DECAY_FRAMES=4: column 0 h=16 once, then h=0 → peak at row 0 is white; it moves to row 1 after the 4th subsequent frame.
